// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//   Single-outstanding AXI4-Lite initiator. A command taken on the cmd_*
//   valid/ready port becomes one complete AXI4-Lite write (AW + W, then B) or
//   read (AR, then R). The slave response comes back as a one-cycle rsp_valid
//   strobe, and rsp_write/rsp_rdata/rsp_resp hold their values until the next
//   completion.
//
// Parameters
//   ADDR_WIDTH   : width of cmd_addr and of the AW/AR address buses.
//   STALL_CYCLES : watchdog threshold in cycles; 0 disables stall.
//
// Ports
//   m_axi_aclk, m_axi_areset    : clock, async active-high reset
//   cmd_valid/cmd_ready         : command handshake (ready == engine idle)
//   cmd_write/addr/wdata/wstrb  : command payload
//   rsp_valid                   : one-cycle completion strobe
//   rsp_write/rsp_rdata/rsp_resp: completion info, held until next completion
//   stall                       : current transaction outstanding >= STALL_CYCLES
//   m_axi_*                     : AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STALL_CYCLES = 256
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  // command / response port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  stall,
  // write address channel
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // write data channel
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // write response channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // read data channel
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,   // AW and/or W still pending
    WRESP,
    RADDR,
    RDATA
  } state_t;

  // The counter must be able to hold STALL_CYCLES itself (it saturates there).
  localparam int              CNT_W   = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        stall_cnt;

  // One address register serves both AW and AR: only one of them is ever valid.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational logic below uses blocking (=).
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nxt    = state;
    cmd_ready    = (state == IDLE);
    m_axi_bready = (state == WRESP);
    m_axi_rready = (state == RDATA);
    accept       = cmd_valid && (state == IDLE);
    // A channel counts as done if it already handshook or handshakes now.
    aw_done      = !m_axi_awvalid || m_axi_awready;
    w_done       = !m_axi_wvalid  || m_axi_wready;

    case (state)
      IDLE:    if (cmd_valid)          state_nxt = cmd_write ? WADDR : RADDR;
      WADDR:   if (aw_done && w_done)  state_nxt = WRESP;
      WRESP:   if (m_axi_bvalid)       state_nxt = IDLE;
      RADDR:   if (m_axi_arready)      state_nxt = RDATA;
      RDATA:   if (m_axi_rvalid)       state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel valids, payload registers and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      rsp_valid <= 1'b0;

      // Payload is only loaded in IDLE, so it is stable while any valid is up.
      if (accept) begin
        addr_q        <= cmd_addr;
        m_axi_wdata   <= cmd_wdata;
        m_axi_wstrb   <= cmd_wstrb;
        m_axi_awvalid <= cmd_write;
        m_axi_wvalid  <= cmd_write;
        m_axi_arvalid <= !cmd_write;
      end

      // AW, W and AR drop independently on their own handshake.
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid  && m_axi_wready)  m_axi_wvalid  <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;

      if (state == WRESP && m_axi_bvalid) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
      end

      if (state == RDATA && m_axi_rvalid) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b0;
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts the cycles of the state being entered, so the first
  // outstanding cycle reads 1 and stall rises in cycle STALL_CYCLES.
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset)             stall_cnt <= '0;
    else if (state_nxt == IDLE)   stall_cnt <= '0;
    else if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign stall = (STALL_CYCLES != 0) && (stall_cnt == CNT_MAX);

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//   Directed bench for axi_lite_master with STALL_CYCLES = 4. A configurable
//   AXI4-Lite slave (per-channel ready/response latencies, 16-word register
//   file) answers the engine. A transaction-level model predicts every DUT
//   output each cycle from the command and the slave's handshakes; a compare
//   process checks it on every falling edge, and each scenario adds
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

  localparam int STALL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_write, stall;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.ADDR_WIDTH(32), .STALL_CYCLES(STALL)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .stall(stall),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Slave model. Each step runs just after a rising edge: it first books the
  // handshakes that completed on that edge, then drives the next cycle.
  // A ready rises once its valid has been high for <lat> cycles.
  // ---------------------------------------------------------------------------
  int          aw_lat = 1, w_lat = 1, ar_lat = 1, b_lat = 0, r_lat = 0;
  logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [31:0] rdata_cfg = 32'd0;
  bit          use_cfg   = 1'b0;
  logic [31:0] regs [16];

  initial begin
    int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    bit got_aw, got_w, got_ar;
    logic p_awv, p_wv, p_arv, p_br, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr, s_addr, s_data, s_raddr;
    logic [3:0]  p_wstrb, s_strb;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    s_addr = 0; s_data = 0; s_raddr = 0; s_strb = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
        continue;
      end
      if (p_awv && awready) begin got_aw = 1; s_addr = p_awaddr; end
      if (p_wv && wready)   begin got_w = 1; s_data = p_wdata; s_strb = p_wstrb; end
      if (bvalid && p_br) begin
        for (int b = 0; b < 4; b++)
          if (s_strb[b]) regs[s_addr[5:2]][8*b +: 8] = s_data[8*b +: 8];
        got_aw = 0; got_w = 0; bvalid = 0; b_cnt = 0;
      end
      if (p_arv && arready) begin got_ar = 1; s_raddr = p_araddr; end
      if (rvalid && p_rr) begin got_ar = 0; rvalid = 0; r_cnt = 0; end

      awready = awvalid && (aw_wait >= aw_lat - 1);
      aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
      wready  = wvalid && (w_wait >= w_lat - 1);
      w_wait  = (wvalid && !wready) ? w_wait + 1 : 0;
      arready = arvalid && (ar_wait >= ar_lat - 1);
      ar_wait = (arvalid && !arready) ? ar_wait + 1 : 0;

      if (got_aw && got_w && !bvalid) begin
        if (b_cnt >= b_lat) begin bvalid = 1; bresp = bresp_cfg; end
        else b_cnt++;
      end
      if (got_ar && !rvalid) begin
        if (r_cnt >= r_lat) begin
          rvalid = 1;
          rresp  = rresp_cfg;
          rdata  = use_cfg ? rdata_cfg : regs[s_raddr[5:2]];
        end else r_cnt++;
      end

      p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata;
      p_wstrb = wstrb; p_arv = arvalid; p_araddr = araddr;
      p_br = bready; p_rr = rready;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction-level reference model: one outstanding command, which channel
  // is still pending, whether the response phase is open, and how many cycles
  // it has been outstanding. Updated on each edge from bench-side signals only.
  // ---------------------------------------------------------------------------
  bit          m_busy, m_write, m_aw, m_w, m_ar, m_resp_phase, m_rsp_v, m_rsp_w;
  int          m_cycles;
  logic [31:0] m_addr, m_wdata, m_rsp_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_rsp_resp;

  task automatic m_reset();
    m_busy = 0; m_write = 0; m_aw = 0; m_w = 0; m_ar = 0; m_resp_phase = 0;
    m_rsp_v = 0; m_rsp_w = 0; m_cycles = 0; m_addr = 0; m_wdata = 0;
    m_wstrb = 0; m_rsp_rdata = 0; m_rsp_resp = 0;
  endtask

  task automatic m_complete(input bit w, input logic [31:0] d, input logic [1:0] r);
    m_rsp_v = 1; m_rsp_w = w; m_rsp_rdata = d; m_rsp_resp = r;
    m_busy = 0; m_aw = 0; m_w = 0; m_ar = 0; m_resp_phase = 0; m_cycles = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        m_rsp_v = 0;
        if (!m_busy) begin
          if (cmd_valid) begin
            m_busy = 1; m_write = cmd_write; m_addr = cmd_addr;
            m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
            m_aw = cmd_write; m_w = cmd_write; m_ar = !cmd_write;
            m_resp_phase = 0; m_cycles = 1;
          end
        end else begin
          m_cycles++;
          if (m_write) begin
            if (m_resp_phase) begin
              if (bvalid) m_complete(1'b1, 32'd0, bresp);
            end else begin
              if (m_aw && awready) m_aw = 0;
              if (m_w && wready)   m_w = 0;
              if (!m_aw && !m_w)   m_resp_phase = 1;
            end
          end else begin
            if (m_resp_phase) begin
              if (rvalid) m_complete(1'b0, rdata, rresp);
            end else if (arready) begin
              m_ar = 0; m_resp_phase = 1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare plus activity counters used by the directed checks.
  // ---------------------------------------------------------------------------
  int awv_cycles = 0, wv_cycles = 0, bready_rises = 0, rsp_count = 0;

  initial begin
    logic prev_bready;
    prev_bready = 0;
    forever begin
      @(negedge clk);
      if (!rst) check("cmd_ready", cmd_ready, !m_busy);
      check("awvalid",   awvalid,   m_aw);
      check("wvalid",    wvalid,    m_w);
      check("arvalid",   arvalid,   m_ar);
      check("bready",    bready,    m_busy && m_write && m_resp_phase);
      check("rready",    rready,    m_busy && !m_write && m_resp_phase);
      check("rsp_valid", rsp_valid, m_rsp_v);
      check("rsp_write", rsp_write, m_rsp_w);
      check("rsp_rdata", rsp_rdata, m_rsp_rdata);
      check("rsp_resp",  rsp_resp,  m_rsp_resp);
      check("stall",     stall,     m_busy && (m_cycles >= STALL));
      check("awprot",    awprot,    3'b000);
      check("arprot",    arprot,    3'b000);
      if (m_aw) check("awaddr", awaddr, m_addr);
      if (m_w) begin
        check("wdata", wdata, m_wdata);
        check("wstrb", wstrb, m_wstrb);
      end
      if (m_ar) check("araddr", araddr, m_addr);
      if (!rst) begin
        if (awvalid) awv_cycles++;
        if (wvalid)  wv_cycles++;
        if (bready && !prev_bready) bready_rises++;
        if (rsp_valid) rsp_count++;
      end
      prev_bready = bready;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Both are entered just after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold, output int acc);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    acc = cyc;
    check("cmd accepted within budget", ok, 1);
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int rc);
    bit ok;
    ok = 0;
    rc = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; rc = cyc; end
    end
    check("rsp within budget", ok, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int acc, acc2, rc, awv0, wv0, br0, rs0;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset stall", stall, 0);
    @(posedge clk); #1;

    // Zero-wait write: rsp_valid in the third cycle after acceptance.
    send_cmd(1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 1'b0, acc);
    wait_rsp(rc);
    check("zw write latency", rc - acc, 2);
    check("zw write resp", rsp_resp, 2'd0);
    check("zw write rsp_write", rsp_write, 1);
    check("zw write rdata", rsp_rdata, 32'd0);
    check("zw write slave reg", regs[1], 32'hA5A5_0001);
    @(posedge clk); #1;

    // Split write handshake: AW waits 3 cycles, W immediate.
    aw_lat = 3; w_lat = 1;
    awv0 = awv_cycles; wv0 = wv_cycles; br0 = bready_rises; rs0 = rsp_count;
    send_cmd(1'b1, 32'h10, 32'h0BAD_BEEF, 4'hF, 1'b0, acc);
    wait_rsp(rc);
    repeat (3) @(negedge clk);
    check("split awvalid cycles", awv_cycles - awv0, 3);
    check("split wvalid cycles", wv_cycles - wv0, 1);
    check("split bready phases", bready_rises - br0, 1);
    check("split rsp count", rsp_count - rs0, 1);
    check("split slave reg", regs[4], 32'h0BAD_BEEF);
    aw_lat = 1;
    @(posedge clk); #1;

    // Read with SLVERR, rvalid delayed 2 cycles.
    use_cfg = 1; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'd2; r_lat = 2;
    send_cmd(1'b0, 32'h8, 32'd0, 4'h0, 1'b0, acc);
    wait_rsp(rc);
    check("rd err latency", rc - acc, 4);
    check("rd err rdata", rsp_rdata, 32'h1234_5678);
    check("rd err resp", rsp_resp, 2'd2);
    check("rd err rsp_write", rsp_write, 0);
    use_cfg = 0; rresp_cfg = 2'd0; r_lat = 0;
    @(posedge clk); #1;

    // Back-to-back: partial-strobe write, read of the same word, cmd_valid held.
    send_cmd(1'b1, 32'hC, 32'hCAFE_F00D, 4'h5, 1'b1, acc);
    send_cmd(1'b0, 32'hC, 32'd0, 4'h0, 1'b0, acc2);
    check("b2b second accept edge", acc2 - acc, 3);
    wait_rsp(rc);
    check("b2b read data", rsp_rdata, 32'h00FE_000D);
    check("b2b read rsp_write", rsp_write, 0);
    @(posedge clk); #1;

    // Watchdog: arready held off for 8 cycles.
    ar_lat = 8;
    send_cmd(1'b0, 32'h4, 32'd0, 4'h0, 1'b0, acc);
    repeat (3) @(negedge clk);
    check("stall low in cycle 3", stall, 0);
    @(negedge clk);
    check("stall high in cycle 4", stall, 1);
    check("arvalid held while stalled", arvalid, 1);
    wait_rsp(rc);
    check("stall cleared at idle", stall, 0);
    check("stalled read data", rsp_rdata, 32'hA5A5_0001);
    ar_lat = 1;
    @(posedge clk); #1;

    // Reset asserted between edges while in WADDR.
    aw_lat = 20; w_lat = 20;
    send_cmd(1'b1, 32'h14, 32'h5555_AAAA, 4'hF, 1'b0, acc);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("async rst awvalid", awvalid, 0);
    check("async rst wvalid", wvalid, 0);
    check("async rst rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #2 rst = 0;
    aw_lat = 1; w_lat = 1;
    @(negedge clk);
    check("cmd_ready after release", cmd_ready, 1);
    rs0 = rsp_count;
    repeat (8) @(negedge clk);
    check("no rsp after reset", rsp_count - rs0, 0);
    @(posedge clk); #1;
    send_cmd(1'b0, 32'h14, 32'd0, 4'h0, 1'b0, acc);
    wait_rsp(rc);
    check("aborted write left reg", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator engine that turns single-word commands from a simple valid/ready command port into complete AXI4-Lite write or read transactions, then returns the response on a one-cycle result strobe. It is the bus-driving end of the custom AXI Lite GPIO interface: it replaces hand-written bench stimulus and lets on-chip logic (sequencers, debug bridges) access `axi_lite_gpio` and other AXI-Lite slaves. One transaction is outstanding at a time, and there is no burst support.

## Interface
- `ADDR_WIDTH`, 32, width of the command address and `m_axi_awaddr`/`m_axi_araddr`.
- `STALL_CYCLES`, 256, watchdog threshold in clock cycles; 0 disables the `stall` output.
- Data width is fixed at 32 and strobe width at 4.

Ports:
- `m_axi_aclk` in 1: the single clock. All logic is rising-edge.
- `m_axi_areset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the engine is idle and accepts a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: byte address.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write byte strobes.
- `rsp_valid` out 1: one-cycle pulse when a transaction completes.
- `rsp_write` out 1: type of the completed transaction.
- `rsp_rdata` out 32: read data. Holds 0 after a write.
- `rsp_resp` out 2: BRESP or RRESP as received from the slave.
- `stall` out 1: the current transaction has been outstanding for at least `STALL_CYCLES` cycles.
- `m_axi_awaddr` out ADDR_WIDTH, `m_axi_awprot` out 3, `m_axi_awvalid` out 1, `m_axi_awready` in 1
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1
- `m_axi_araddr` out ADDR_WIDTH, `m_axi_arprot` out 3, `m_axi_arvalid` out 1, `m_axi_arready` in 1
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1

## Operation
- **States:** `IDLE`, `WADDR` (AW and/or W pending), `WRESP`, `RADDR`, `RDATA`.
- **`IDLE`:** `cmd_ready`=1. On `cmd_valid`, the engine registers addr, data and strb.
  - A write goes to `WADDR` and sets `awvalid`=`wvalid`=1.
  - A read goes to `RADDR` and sets `arvalid`=1.
- **`WADDR`:** the AW and W channels are independent.
  - `awvalid` clears on the edge where `awvalid`&&`awready`.
  - `wvalid` clears on the edge where `wvalid`&&`wready`.
  - The two handshakes may complete in the same cycle or in either order.
  - When both are done (including simultaneously), go to `WRESP`.
- **`WRESP`:** `bready`=1. On `bvalid`, capture `bresp`, pulse `rsp_valid` with `rsp_write`=1 and `rsp_rdata`=0, then return to `IDLE`.
- **`RADDR`:** `arvalid` held until `arready`, then go to `RDATA`.
- **`RDATA`:** `rready`=1. On `rvalid`, capture `rdata`/`rresp`, pulse `rsp_valid` with `rsp_write`=0, then return to `IDLE`.
- **Prot and ready signals:** `awprot`=`arprot`=3'b000 always. `bready`/`rready` are high only in their response states.
- **Valid stability:** a valid is never withdrawn before its handshake, and addr/data/strb are stable while the corresponding valid is high.
- **Response value:** SLVERR and DECERR are reported unmodified. The engine does not retry.
- **Stall counter:**
  - Counts cycles in any non-`IDLE` state and saturates at `STALL_CYCLES`.
  - Clears when `IDLE` is entered.
  - `stall` = (count == `STALL_CYCLES`) && (`STALL_CYCLES` != 0).
  - Informational only; it never aborts a transaction.
- **Reset:** asynchronous assertion immediately forces `IDLE` and drives all outputs to 0, even mid-transaction. Release takes effect on the next clock edge.

## Timing
- **Reset values:** all outputs 0, except `cmd_ready`, which is 1 after reset.
- **Command acceptance:** the command is accepted at edge E0, the rising edge where `cmd_valid`&&`cmd_ready`. `cmd_ready` is low from E0 to the return to `IDLE`.
- **Channel valids:** `awvalid`/`wvalid`/`arvalid` are high in the cycle after E0.
- **Zero-wait write:**
  - `awready`=`wready`=1 at E1 and `bvalid`=1 at E2.
  - `rsp_valid` is high in the cycle after E2, and `cmd_ready` is high in that same cycle.
  - The next command can therefore be accepted back-to-back at E3.
- **Zero-wait read:** identical timing with the AR/R channels.
- **Response strobe:** `rsp_valid` is exactly one cycle. `rsp_rdata`/`rsp_resp`/`rsp_write` hold until the next completion.
- **Early `bvalid`/`rvalid`:** if the slave raises `bvalid`/`rvalid` before the engine reaches the response state, it is accepted once the state is reached (the slave holds it per protocol).

## Test plan
- **Zero-wait write:** write addr 0x4, data 0xA5A5_0001, strb 0xF to a zero-wait slave model with BRESP=OKAY → `rsp_valid` 3 cycles after acceptance, `rsp_resp`=0, slave register = 0xA5A5_0001.
- **Split write handshake:** `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` after 3. A single `bready` phase follows, and there is exactly one `rsp_valid`.
- **Read with error:** read addr 0x8 where the slave returns rdata 0x1234_5678, RRESP=SLVERR, `rvalid` delayed 2 cycles → `rsp_rdata`=0x1234_5678, `rsp_resp`=2, `rsp_write`=0.
- **Back-to-back:** write then read held on `cmd_valid` continuously → the second is accepted in the `rsp_valid` cycle of the first. No valid overlaps across transactions.
- **Watchdog:** `STALL_CYCLES`=4 with the slave never asserting `arready` → `stall` rises at the 4th outstanding cycle and `arvalid` stays high. After `arready`/`rvalid` arrive, `stall` clears on return to `IDLE`.
- **Reset mid-transaction:** assert `m_axi_areset` mid-way between edges while in `WADDR` → `awvalid`/`wvalid`/`rsp_valid` go 0 immediately and `cmd_ready`=1 after release. No response is emitted.
